seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter N, default 8: operand, quotient and remainder width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1: request a division; sampled on rising clk edges.
REQ-005 SHALL have port dividend  input  N: numerator; sampled only in the cycle start is accepted.
REQ-006 SHALL have port divisor  input  N: denominator; sampled only in the cycle start is accepted.
REQ-007 SHALL have port busy  output  1: high while a division is in progress.
REQ-008 SHALL have port done  output  1: one-cycle pulse when results become valid.
REQ-009 SHALL have port quotient  output  N: result quotient; held stable until the next accepted start.
REQ-010 SHALL have port remainder  output  N: result remainder; held stable until the next accepted start.
REQ-011 SHALL have port div_by_zero  output  1: divisor was zero for the last completed operation; held with the results.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; start in RUN is ignored with no effect on the operation in flight.
REQ-014 On accepted start with divisor != 0: latch the operands, clear the partial remainder, load the iteration counter with N-1, enter RUN.
REQ-015 SHALL perform one restoring-division step per RUN cycle: shift {remainder, dividend} left by 1; trial subtract the divisor from the upper N+1 bits; keep the difference and set the quotient bit to 1 if there is no borrow, else restore and set it to 0.
REQ-016 SHALL hold the trial subtraction at N+1 bits so that no intermediate overflow occurs at divisor >= 2^(N-1).
REQ-017 SHALL leave RUN after exactly N step cycles, then enter DONE for one cycle and then IDLE.
REQ-018 Latency: start accepted at edge k -> busy high for cycles k+1..k+N; done high for the cycle after edge k+N+1 only.
REQ-019 On accepted start with divisor == 0: go directly to DONE (done one cycle after acceptance), set quotient to all ones, remainder to dividend, and div_by_zero to 1.
REQ-020 SHALL clear div_by_zero when a nonzero-divisor operation is accepted.
REQ-021 SHALL update quotient and remainder only on entry to DONE; they keep their old values during RUN.
REQ-022 A start in the DONE cycle SHALL be accepted (back-to-back operation) and SHALL enter RUN on the next edge.

Reset
REQ-023 While rst is high: state = IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, counter = 0.
REQ-024 Reset asserted mid-operation SHALL abort the operation immediately; no done pulse is produced for it.

Configuration
REQ-025 With macro SEQ_DIVIDER_SIGNED_EN defined, operands SHALL be two's complement:
- divide the magnitudes
- negate the quotient if the operand signs differ
- give the remainder the sign of the dividend (truncation toward zero)
- sign fix-up in the DONE-entry cycle, with no added latency
- most-negative / -1 -> quotient = most-negative, remainder = 0
REQ-026 Without SEQ_DIVIDER_SIGNED_EN, operands SHALL be unsigned and no sign logic is synthesized.

Structure
REQ-027 A shared package seq_divider_pkg SHALL hold the FSM state enum typedef (IDLE, RUN, DONE) and the counter-width function clog2-based on N.
REQ-028 The trial subtract SHALL be one combinational sub-module, nbit_subtractor: N+1-bit a minus b, with borrow out, built from full-adder cells with inverted b and carry-in 1.

Verification (N=8, unsigned unless noted)
REQ-029 start, dividend=200, divisor=7 -> busy for 8 cycles; done pulse 9 cycles after acceptance; quotient=28, remainder=4, div_by_zero=0.
REQ-030 dividend=45, divisor=0 -> done 1 cycle after acceptance; quotient=255, remainder=45, div_by_zero=1; busy never high.
REQ-031 255/1 then start held high during RUN with 10/3 -> first result quotient=255, remainder=0; the mid-RUN start is ignored; 10/3 is accepted only when re-asserted in the DONE cycle, giving quotient=3, remainder=1.
REQ-032 200/250 -> quotient=0, remainder=200; 255/128 -> quotient=1, remainder=127 (checks N+1-bit subtract).
REQ-033 rst pulsed in the 4th RUN cycle -> all outputs 0 asynchronously, no done pulse; a new 9/3 afterwards -> quotient=3, remainder=0.
REQ-034 SEQ_DIVIDER_SIGNED_EN: -7/2 -> quotient=-3 (0xFD), remainder=-1 (0xFF); -128/-1 -> quotient=0x80, remainder=0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Build with SEQ_DIVIDER_SIGNED_EN defined for two's-complement operands.
package seq_divider_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Width of a counter that must hold the values 0..n-1.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_divider_nbit_subtractor.sv
// Ripple subtractor a - b built from full-adder cells (b inverted, carry-in 1).
// borrow is high when b > a, i.e. when the final carry out is low.
module nbit_subtractor #(
   parameter int W = 9
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow
);

   logic [W:0] carry;

   assign carry[0] = 1'b1;

   genvar i;
   generate
      for (i = 0; i < W; i++) begin : g_fa
         assign diff[i]      = a[i] ^ ~b[i] ^ carry[i];
         assign carry[i + 1] = (a[i] & ~b[i]) | (carry[i] & (a[i] ^ ~b[i]));
      end
   endgenerate

   assign borrow = ~carry[W];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per RUN cycle, N cycles per divide.
// Optional macro SEQ_DIVIDER_SIGNED_EN selects two's-complement operands.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = cnt_width(N);

   state_t        state;
   state_t        next_state;
   logic [CW-1:0] count;
   logic [N-1:0]  dvs_r;
   logic [N-1:0]  shift_q;
   logic [N-1:0]  part_rem;

   logic          accept;
   logic          zero_dvs;
   logic [N-1:0]  dvd_mag;
   logic [N-1:0]  dvs_mag;
   logic [N:0]    shifted;
   logic [N:0]    diff;
   logic          borrow;
   logic          unused_diff_msb;
   logic [N-1:0]  step_quo;
   logic [N-1:0]  step_rem;
   logic [N-1:0]  final_quo;
   logic [N-1:0]  final_rem;

   assign accept   = start && ((state == IDLE) || (state == DONE));
   assign zero_dvs = (divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic neg_q;
   logic neg_r;

   assign dvd_mag   = dividend[N-1] ? -dividend : dividend;
   assign dvs_mag   = divisor[N-1] ? -divisor : divisor;
   assign final_quo = neg_q ? -step_quo : step_quo;
   assign final_rem = neg_r ? -step_rem : step_rem;
`else
   assign dvd_mag   = dividend;
   assign dvs_mag   = divisor;
   assign final_quo = step_quo;
   assign final_rem = step_rem;
`endif

   // The trial subtract is one bit wider than the operands so a divisor with
   // its top bit set never overflows the shifted partial remainder.
   assign shifted = {part_rem, shift_q[N-1]};

   nbit_subtractor #(
      .W(N + 1)
   ) u_sub (
      .a     (shifted),
      .b     ({1'b0, dvs_r}),
      .diff  (diff),
      .borrow(borrow)
   );

   assign unused_diff_msb = diff[N];
   assign step_rem        = borrow ? shifted[N-1:0] : diff[N-1:0];
   assign step_quo        = {shift_q[N-2:0], ~borrow};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = zero_dvs ? DONE : RUN;
            end
         end
         RUN: begin
            if (count == '0) begin
               next_state = DONE;
            end
         end
         DONE: begin
            if (start) begin
               next_state = zero_dvs ? DONE : RUN;
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Results are only written on entry to DONE, so they stay put while a new
   // division is running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count       <= '0;
         dvs_r       <= '0;
         shift_q     <= '0;
         part_rem    <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else if (accept) begin
         if (zero_dvs) begin
            count       <= '0;
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end else begin
            count       <= CW'(N - 1);
            dvs_r       <= dvs_mag;
            shift_q     <= dvd_mag;
            part_rem    <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q       <= dividend[N-1] ^ divisor[N-1];
            neg_r       <= dividend[N-1];
`endif
         end
      end else if (state == RUN) begin
         shift_q  <= step_quo;
         part_rem <= step_rem;
         if (count == '0) begin
            quotient  <= final_quo;
            remainder <= final_rem;
         end else begin
            count <= count - CW'(1);
         end
      end
   end

endmodule
